// File: rtl/boa_pkg.sv
// Shared types for the boa memory scheduler: FSM state encoding and stall counter width.
package boa_pkg;

   typedef enum logic {
      SCHED_IDLE = 1'b0,
      SCHED_BUSY = 1'b1
   } sched_state_e;

   localparam int stall_w = 16;

endpackage

// File: rtl/boa_mem_bus.sv
// One-cycle-latency memory bus: request in cycle t, ready/rdata answered in t+1.
// A request is re=1 or any byte-enable in we; a requester seeing ready=0 holds its request stable.
interface boa_mem_bus #(
   parameter int alen = 32,
   parameter int dlen = 32
) ();

   logic              re;
   logic [dlen/8-1:0] we;
   logic [alen-1:0]   addr;
   logic [dlen-1:0]   wdata;
   logic [dlen-1:0]   rdata;
   logic              ready;

   modport CPU (output re, we, addr, wdata, input rdata, ready);
   modport MEM (input re, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/boa_mem_sched_pick.sv
// Masked round-robin picker: the lowest requester above the current owner, else wrap to the lowest.
// Purely combinational; the owner itself is chosen only when nobody else requests.
module boa_mem_sched_pick #(
   parameter int n = 2
) (
   input  logic [n-1:0] req,
   input  logic [n-1:0] owner,
   output logic [n-1:0] next
);

   localparam logic [n-1:0] one = n'(1);

   logic [n-1:0] hi_mask;
   logic [n-1:0] hi_req;
   logic [n-1:0] pool;

   always_comb begin
      // Bits strictly above the one-hot owner; an owner at the top bit yields an empty mask.
      hi_mask = ~((owner << 1) - one);
      hi_req  = req & hi_mask;
      pool    = (|hi_req) ? hi_req : req;
      next    = pool & (~pool + one);
   end

endmodule

// File: rtl/boa_mem_sched.sv
// Round-robin scheduler sharing one boa_mem_bus target between several requesters, with burst limit and lock.
// Optional per-port stall counters are built when BOA_MEM_SCHED_STATS_EN is defined.
module boa_mem_sched
   import boa_pkg::*;
#(
   parameter int alen      = 32,
   parameter int dlen      = 32,
   parameter int cpus      = 2,
   parameter int max_burst = 4
) (
   input  logic            clk,
   input  logic            rst,
   boa_mem_bus.MEM         cpu [cpus],
   boa_mem_bus.CPU         mem,
   input  logic [cpus-1:0] lock,
   output logic [cpus-1:0] owner
`ifdef BOA_MEM_SCHED_STATS_EN
   ,
   input  logic                         stats_clr,
   output logic [cpus-1:0][stall_w-1:0] stall_cnt
`endif
);

   localparam int              bw        = $clog2(max_burst + 1);
   localparam int              wb        = dlen / 8;
   localparam logic [bw-1:0]   burst_lim = bw'(max_burst);
   localparam logic [bw-1:0]   one_b     = bw'(1);
   localparam logic [cpus-1:0] owner_rst = cpus'(1);

   sched_state_e    state_q, state_n;
   logic [cpus-1:0] owner_q, owner_n;
   logic [cpus-1:0] wait_q, wait_n;
   logic [bw-1:0]   bcnt_q, bcnt_n;
   logic [cpus-1:0] req, pick, issue;
   logic            own_req, other_req, own_lock;

   logic            c_re    [cpus];
   logic [wb-1:0]   c_we    [cpus];
   logic [alen-1:0] c_addr  [cpus];
   logic [dlen-1:0] c_wdata [cpus];

   logic            mem_re;
   logic [wb-1:0]   mem_we;
   logic [alen-1:0] mem_addr;
   logic [dlen-1:0] mem_wdata;

   for (genvar i = 0; i < cpus; i++) begin : g_port
      assign c_re[i]    = cpu[i].re;
      assign c_we[i]    = cpu[i].we;
      assign c_addr[i]  = cpu[i].addr;
      assign c_wdata[i] = cpu[i].wdata;
      assign req[i]     = cpu[i].re | (|cpu[i].we);
      // The port whose access is in flight follows the target; a passed-over requester stalls.
      assign cpu[i].ready = (state_q == SCHED_BUSY && owner_q[i]) ? mem.ready : !wait_q[i];
      assign cpu[i].rdata = mem.rdata;
   end

   boa_mem_sched_pick #(.n(cpus)) u_pick (
      .req   (req),
      .owner (owner_q),
      .next  (pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SCHED_IDLE;
         owner_q <= owner_rst;
         wait_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_n;
         owner_q <= owner_n;
         wait_q  <= wait_n;
         bcnt_q  <= bcnt_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      owner_n   = owner_q;
      bcnt_n    = bcnt_q;
      issue     = '0;
      own_req   = |(req & owner_q);
      other_req = |(req & ~owner_q);
      own_lock  = |(lock & owner_q);
      if (state_q == SCHED_BUSY && !mem.ready) begin
         issue = owner_q;
      end else if (own_req && (own_lock || bcnt_q < burst_lim || !other_req)) begin
         issue   = owner_q;
         bcnt_n  = (bcnt_q == '1) ? bcnt_q : bcnt_q + one_b;
         state_n = SCHED_BUSY;
      end else if (other_req && !own_lock) begin
         issue   = pick;
         owner_n = pick;
         bcnt_n  = one_b;
         state_n = SCHED_BUSY;
      end else begin
         // Nobody to serve, or a locked owner is between the halves of its atomic sequence.
         bcnt_n  = '0;
         state_n = SCHED_IDLE;
      end
      wait_n = req & ~issue;
   end

   always_comb begin
      mem_re    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int i = 0; i < cpus; i++) begin
         if (issue[i]) begin
            mem_re    = c_re[i];
            mem_we    = c_we[i];
            mem_addr  = c_addr[i];
            mem_wdata = c_wdata[i];
         end
      end
   end

   assign mem.re    = mem_re;
   assign mem.we    = mem_we;
   assign mem.addr  = mem_addr;
   assign mem.wdata = mem_wdata;
   assign owner     = owner_q;

`ifdef BOA_MEM_SCHED_STATS_EN
   localparam logic [stall_w-1:0] one_s = stall_w'(1);

   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < cpus; i++) begin
            if (wait_q[i] && stall_cnt[i] != '1) stall_cnt[i] <= stall_cnt[i] + one_s;
         end
      end
   end
`endif

endmodule

// File: tb/tb_boa_mem_sched.sv
// Directed bench for boa_mem_sched: a 2-port instance for burst/hold/lock/reset and a 3-port instance
// with max_burst=1 for rotation; stall counters are checked when BOA_MEM_SCHED_STATS_EN is defined.
module tb_boa_mem_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   boa_mem_bus #(.alen(32), .dlen(32)) cpu_a [2] ();
   boa_mem_bus #(.alen(32), .dlen(32)) mem_a ();
   boa_mem_bus #(.alen(32), .dlen(32)) cpu_b [3] ();
   boa_mem_bus #(.alen(32), .dlen(32)) mem_b ();

   logic        a_re    [2];
   logic [3:0]  a_we    [2];
   logic [31:0] a_addr  [2];
   logic [31:0] a_wdata [2];
   logic        a_ready [2];
   logic [31:0] a_rdata [2];
   logic        b_re    [3];
   logic [31:0] b_addr  [3];
   logic [1:0]  lock_a, owner_a;
   logic [2:0]  lock_b, owner_b;
   logic        m_ready;
   logic [31:0] m_rdata;
`ifdef BOA_MEM_SCHED_STATS_EN
   logic [1:0][15:0] stall_a;
   logic [2:0][15:0] stall_b;
`endif

   for (genvar i = 0; i < 2; i++) begin : g_a
      assign cpu_a[i].re    = a_re[i];
      assign cpu_a[i].we    = a_we[i];
      assign cpu_a[i].addr  = a_addr[i];
      assign cpu_a[i].wdata = a_wdata[i];
      assign a_ready[i]     = cpu_a[i].ready;
      assign a_rdata[i]     = cpu_a[i].rdata;
   end

   for (genvar i = 0; i < 3; i++) begin : g_b
      assign cpu_b[i].re    = b_re[i];
      assign cpu_b[i].we    = 4'h0;
      assign cpu_b[i].addr  = b_addr[i];
      assign cpu_b[i].wdata = 32'h0;
   end

   assign mem_a.ready = m_ready;
   assign mem_a.rdata = m_rdata;
   assign mem_b.ready = 1'b1;
   assign mem_b.rdata = 32'h0;

   boa_mem_sched #(.alen(32), .dlen(32), .cpus(2), .max_burst(4)) dut_a (
      .clk   (clk),
      .rst   (rst),
      .cpu   (cpu_a),
      .mem   (mem_a),
      .lock  (lock_a),
      .owner (owner_a)
`ifdef BOA_MEM_SCHED_STATS_EN
      ,
      .stats_clr (1'b0),
      .stall_cnt (stall_a)
`endif
   );

   boa_mem_sched #(.alen(32), .dlen(32), .cpus(3), .max_burst(1)) dut_b (
      .clk   (clk),
      .rst   (rst),
      .cpu   (cpu_b),
      .mem   (mem_b),
      .lock  (lock_b),
      .owner (owner_b)
`ifdef BOA_MEM_SCHED_STATS_EN
      ,
      .stats_clr (1'b0),
      .stall_cnt (stall_b)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int p, input logic re, input logic [3:0] we, input logic [31:0] addr);
      a_re[p]   = re;
      a_we[p]   = we;
      a_addr[p] = addr;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         set_a(i, 1'b0, 4'h0, 32'h0);
         a_wdata[i] = 32'h0;
      end
      for (int i = 0; i < 3; i++) begin
         b_re[i]   = 1'b0;
         b_addr[i] = 32'h0;
      end
      lock_a  = 2'b00;
      lock_b  = 3'b000;
      m_ready = 1'b1;
      m_rdata = 32'h0;

      // Reset state
      tick(); tick(); #2;
      check("rst_owner_a", owner_a, 32'h1);
      check("rst_owner_b", owner_b, 32'h1);
      check("rst_rdy0", a_ready[0], 32'h1);
      check("rst_rdy1", a_ready[1], 32'h1);
      check("rst_mem_re", mem_a.re, 32'h0);

      // Single port back-to-back reads
      tick(); rst = 1'b0; set_a(0, 1'b1, 4'h0, 32'h100); #2;
      check("t1_c1_re", mem_a.re, 32'h1);
      check("t1_c1_addr", mem_a.addr, 32'h100);
      check("t1_c1_rdy1", a_ready[1], 32'h1);
      tick(); set_a(0, 1'b1, 4'h0, 32'h104); m_rdata = 32'hDEAD0100; #2;
      check("t1_c2_rdy0", a_ready[0], 32'h1);
      check("t1_c2_rdata", a_rdata[0], 32'hDEAD0100);
      check("t1_c2_addr", mem_a.addr, 32'h104);
      check("t1_c2_rdy1", a_ready[1], 32'h1);
      tick(); set_a(0, 1'b0, 4'h0, 32'h0); m_rdata = 32'hDEAD0104; #2;
      check("t1_c3_rdy0", a_ready[0], 32'h1);
      check("t1_c3_rdata", a_rdata[0], 32'hDEAD0104);
      check("t1_c3_re", mem_a.re, 32'h0);
      check("t1_c3_rdy1", a_ready[1], 32'h1);
      tick(); #2;
      check("t1_c4_rdy0", a_ready[0], 32'h1);

      // Both ports continuously requesting: runs of four
      for (int k = 0; k < 9; k++) begin
         tick(); set_a(0, 1'b1, 4'h0, 32'h200); set_a(1, 1'b1, 4'h0, 32'h300); #2;
         check($sformatf("t2_addr_%0d", k), mem_a.addr, (k >= 4 && k < 8) ? 32'h300 : 32'h200);
         check($sformatf("t2_rdy0_%0d", k), a_ready[0], (k < 5) ? 32'h1 : 32'h0);
         check($sformatf("t2_rdy1_%0d", k), a_ready[1], (k == 0 || k >= 5) ? 32'h1 : 32'h0);
         check($sformatf("t2_owner_%0d", k), owner_a, (k >= 5) ? 32'h2 : 32'h1);
      end
      tick(); set_a(0, 1'b0, 4'h0, 32'h0); set_a(1, 1'b0, 4'h0, 32'h0); #2;
      check("t2_end_re", mem_a.re, 32'h0);
      check("t2_end_rdy0", a_ready[0], 32'h1);

      // Slow target: three stalled cycles, then port 1 on completion
      tick(); set_a(0, 1'b1, 4'h0, 32'h400); set_a(1, 1'b1, 4'h0, 32'h500); #2;
      check("t3_issue_addr", mem_a.addr, 32'h400);
      for (int k = 0; k < 3; k++) begin
         tick(); m_ready = 1'b0; #2;
         check($sformatf("t3_hold_addr_%0d", k), mem_a.addr, 32'h400);
         check($sformatf("t3_hold_re_%0d", k), mem_a.re, 32'h1);
         check($sformatf("t3_hold_owner_%0d", k), owner_a, 32'h1);
         check($sformatf("t3_hold_rdy0_%0d", k), a_ready[0], 32'h0);
         check($sformatf("t3_hold_rdy1_%0d", k), a_ready[1], 32'h0);
      end
      tick(); m_ready = 1'b1; set_a(0, 1'b0, 4'h0, 32'h0); #2;
      check("t3_done_addr", mem_a.addr, 32'h500);
      check("t3_done_rdy0", a_ready[0], 32'h1);
      check("t3_done_rdy1", a_ready[1], 32'h0);
      tick(); set_a(1, 1'b0, 4'h0, 32'h0); #2;
      check("t3_after_rdy1", a_ready[1], 32'h1);
      check("t3_after_owner", owner_a, 32'h2);
      check("t3_after_re", mem_a.re, 32'h0);

      // Locked owner keeps ten writes despite a waiting port 0
      for (int k = 0; k < 10; k++) begin
         tick(); lock_a = 2'b10;
         set_a(0, 1'b1, 4'h0, 32'h600);
         set_a(1, 1'b0, 4'hF, 32'h700 + 32'(4 * k));
         a_wdata[1] = 32'(k);
         #2;
         check($sformatf("t4_addr_%0d", k), mem_a.addr, 32'h700 + 32'(4 * k));
         check($sformatf("t4_we_%0d", k), mem_a.we, 32'hF);
         check($sformatf("t4_wdata_%0d", k), mem_a.wdata, 32'(k));
         check($sformatf("t4_owner_%0d", k), owner_a, 32'h2);
         if (k == 4) check("t4_rdy0_wait", a_ready[0], 32'h0);
      end
      tick(); lock_a = 2'b00; set_a(1, 1'b0, 4'hF, 32'h728); #2;
      check("t4_unlock_addr", mem_a.addr, 32'h600);
      check("t4_unlock_re", mem_a.re, 32'h1);
      check("t4_unlock_we", mem_a.we, 32'h0);
      check("t4_unlock_rdy0", a_ready[0], 32'h0);
      tick(); set_a(0, 1'b0, 4'h0, 32'h0); #2;
      check("t4_back_addr", mem_a.addr, 32'h728);
      check("t4_back_owner", owner_a, 32'h1);
      check("t4_back_rdy0", a_ready[0], 32'h1);
      check("t4_back_rdy1", a_ready[1], 32'h0);
      tick(); set_a(1, 1'b0, 4'h0, 32'h0); #2;
      check("t4_end_rdy1", a_ready[1], 32'h1);
      check("t4_end_owner", owner_a, 32'h2);

      // Reset in the middle of a stalled access
      tick(); set_a(0, 1'b1, 4'h0, 32'h800); set_a(1, 1'b1, 4'h0, 32'h900); #2;
      check("t5_issue_addr", mem_a.addr, 32'h900);
      tick(); m_ready = 1'b0; rst = 1'b1; #2;
      check("t5_hold_addr", mem_a.addr, 32'h900);
      tick(); rst = 1'b0; m_ready = 1'b1; set_a(0, 1'b0, 4'h0, 32'h0); set_a(1, 1'b0, 4'h0, 32'h0); #2;
      check("t5_owner", owner_a, 32'h1);
      check("t5_rdy0", a_ready[0], 32'h1);
      check("t5_rdy1", a_ready[1], 32'h1);
      check("t5_re", mem_a.re, 32'h0);
      check("t5_we", mem_a.we, 32'h0);
`ifdef BOA_MEM_SCHED_STATS_EN
      check("t5_stall0", stall_a[0], 32'h0);
      check("t5_stall1", stall_a[1], 32'h0);
`endif

      // Three ports, max_burst=1: strict rotation
      for (int k = 0; k < 6; k++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            b_re[i]   = 1'b1;
            b_addr[i] = 32'hB00 + 32'(i);
         end
         #2;
         check($sformatf("t6_addr_%0d", k), mem_b.addr, 32'hB00 + 32'(k % 3));
         if (k >= 1) check($sformatf("t6_owner_%0d", k), owner_b, 32'(1 << ((k - 1) % 3)));
      end
      tick();
      for (int i = 0; i < 3; i++) b_re[i] = 1'b0;
      #2;
      check("t6_end_re", mem_b.re, 32'h0);
`ifdef BOA_MEM_SCHED_STATS_EN
      check("t6_stall0", stall_b[0], 32'd3);
      check("t6_stall1", stall_b[1], 32'd3);
      check("t6_stall2", stall_b[2], 32'd4);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/boa_mem_sched.md
Name: boa_mem_sched

Overview:
- Multi-requester scheduler for one shared boa_mem_bus target, e.g. an I-fetch and a D-access port sharing one SRAM.
- Grants the target with round-robin fairness and a bounded burst length.
- Supports a per-port lock for atomic read-modify-write sequences.
- Owns the CPU-side `ready` handshake of every requester, including stall propagation when the target is slow.

Parameters:
- alen, 32, address bus width (at least 8).
- dlen, 32, data bus width (32 or 64).
- cpus, 2, number of requester ports (at least 2).
- max_burst, 4, maximum consecutive grants to one unlocked owner while others wait (at least 1).

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous reset, active-high.
- cpu  boa_mem_bus.MEM[cpus]  -  requester ports.
- mem  boa_mem_bus.CPU  -  shared target port.
- lock  in  cpus  per-port grant lock: while the owner's lock bit is high, ownership never moves.
- owner  out  cpus  one-hot current owner, for debug and trace.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Bus timing: 1-cycle latency.
  - A request (re or any we) is sampled in cycle t.
  - The target answers in t+1 with ready/rdata.
  - If target ready=0 in t+1, the request stays on mem unchanged until ready=1.
- State:
  - owner: one-hot register, reset value 1.
  - pending: target access outstanding, reset 0.
  - bcnt: burst counter, clog2(max_burst+1) bits, reset 0.
  - wait_q[cpus]: port requested but was not issued, reset 0.
- FSM:
  - IDLE (pending=0): arbitrate every cycle.
  - BUSY (pending=1, mem.ready=0): hold; no arbitration; mem signals driven from the owner port unchanged.
  - BUSY with mem.ready=1: access completes; arbitrate in the same cycle (back-to-back issue allowed).
- Arbitration, combinational, only in IDLE or on completion:
  - If the owner requests and (lock[owner] or bcnt < max_burst or no other port requests): keep the owner; bcnt += 1, saturating.
  - Otherwise, pick the next requesting port in round-robin order starting after the owner; set bcnt=1.
  - If nobody requests: owner unchanged, bcnt=0, pending←0, mem.re=0, mem.we=0.
  - Any grant: pending←1, and the granted port's re/we/addr/wdata are muxed to mem.
- Lock: lock of a non-owner port is ignored. Lock never blocks completion of an in-flight access.
- cpu[i].ready:
  - Issued port in the previous cycle: mem.ready.
  - Port that requested but was not issued (wait_q): 0.
  - Otherwise: 1.
- cpu[i].rdata = mem.rdata for all ports; only meaningful when ready=1.
- Requester rule: a requester seeing ready=0 holds its request stable. The scheduler relies on this and does not latch addr/wdata.
- Simultaneous events:
  - A new request from the owner in the completion cycle is treated as a continuation (burst).
  - A request withdrawn while waiting (illegal) clears wait_q next cycle; no error.
- Reset mid-access: pending, wait_q and bcnt cleared, owner=1, all cpu ready=1 in the cycle after reset. The target transaction is abandoned; target is reset together.
- Fairness: with all ports continuously requesting and no lock, each port is granted max_burst consecutive accesses in rotating order.

Optional Feature:
- Macro: BOA_MEM_SCHED_STATS_EN.
- Defined:
  - Adds output stall_cnt, cpus x 16 bits.
  - Per port, counts cycles with wait_q set; saturating at 16'hFFFF; cleared by rst.
  - Adds input stats_clr (1 bit), synchronous clear of all counters.
- Undefined: neither port exists; no counters synthesized.

Decomposition:
- boa_pkg (shared): state enum (SCHED_IDLE, SCHED_BUSY), stall-counter width constant (16).
- Sub-module boa_mem_sched_pick: masked round-robin picker (req, owner → next one-hot), purely combinational, reusable by other arbiters.

Test Plan:
1. Single port 0 reads 0x100, 0x104 back-to-back, target always ready → issue in cycles 1 and 2, ready=1 in cycles 2 and 3, port 1 ready=1 throughout.
2. Ports 0 and 1 request continuously, max_burst=4 → mem.addr alternates four accesses port 0, then four port 1; blocked port's ready=0 during each run.
3. Target holds ready=0 for 3 cycles while port 0 owns and port 1 requests → mem signals stable 3 cycles, owner unchanged, port 1 granted on the completion cycle.
4. Port 1 owns with lock=1 for 10 accesses while port 0 requests → no switch for 10 accesses; lock drops → port 0 granted at the next completion.
5. rst asserted mid-BUSY → owner=1, all cpu ready=1, mem.re=0, mem.we=0 next cycle; stall_cnt=0 when BOA_MEM_SCHED_STATS_EN is defined.
6. cpus=3, all request, max_burst=1 → grant order 0,1,2,0,1,2; with stats, each counter increments 2 per 3 cycles.
